// File: rtl/gaussian_ctrl.sv
// Frame sequencer for the separable 5x5 Gaussian blur datapath: feeds the
// pixel stream, drains the pipeline with zeros, and tags each result.
module gaussian_ctrl #(
  parameter int WIDTH   = 400,
  parameter int HEIGHT  = 300,
  parameter int LATENCY = 802,
  parameter int CW      = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [7:0]    in_pixel,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [7:0]    dp_din,
  output logic          dp_ce,
  output logic          dp_sclr,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] out_x,
  output logic [CW-1:0] out_y,
  output logic          out_last,
  output logic          busy,
  output logic          frame_done
);

  localparam int TOTAL = WIDTH * HEIGHT;
  localparam int SW    = $clog2(TOTAL + LATENCY + 1);
  localparam int AW    = $clog2(TOTAL + 1);
  localparam int FW    = $clog2(LATENCY + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_FLUSH,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t          state;
  logic [SW-1:0]   step_cnt;
  logic [SW-1:0]   step_next;
  logic [AW-1:0]   acc_cnt;
  logic [FW-1:0]   flush_cnt;
  logic [CW-1:0]   next_x;
  logic [CW-1:0]   next_y;
  logic            stall;

  assign stall      = out_valid & ~out_ready;
  assign step_next  = step_cnt + SW'(1);
  assign dp_sclr    = (state == S_CLEAR);
  assign frame_done = (state == S_DONE);
  assign busy       = (state != S_IDLE);

  // Handshake-dependent controls must react in the same cycle as the stall.
  always_comb begin
    in_ready = 1'b0;
    dp_ce    = 1'b0;
    dp_din   = 8'd0;
    case (state)
      S_RUN: begin
        in_ready = ~stall;
        dp_ce    = in_valid & ~stall;
        dp_din   = in_pixel;
      end
      S_FLUSH: dp_ce = ~stall;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      step_cnt  <= '0;
      acc_cnt   <= '0;
      flush_cnt <= '0;
      next_x    <= '0;
      next_y    <= '0;
      out_valid <= 1'b0;
      out_x     <= '0;
      out_y     <= '0;
      out_last  <= 1'b0;
    end else begin
      // A step past the pipeline fill publishes the next raster coordinate.
      if (dp_ce) begin
        step_cnt <= step_next;
        if (step_next > SW'(LATENCY)) begin
          out_valid <= 1'b1;
          out_x     <= next_x;
          out_y     <= next_y;
          out_last  <= (next_x == CW'(WIDTH - 1)) && (next_y == CW'(HEIGHT - 1));
          if (next_x == CW'(WIDTH - 1)) begin
            next_x <= '0;
            next_y <= next_y + CW'(1);
          end else begin
            next_x <= next_x + CW'(1);
          end
        end else begin
          out_valid <= 1'b0;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          step_cnt  <= '0;
          acc_cnt   <= '0;
          flush_cnt <= '0;
          next_x    <= '0;
          next_y    <= '0;
          out_valid <= 1'b0;
          out_x     <= '0;
          out_y     <= '0;
          out_last  <= 1'b0;
          if (start) state <= S_CLEAR;
        end
        S_CLEAR: state <= S_RUN;
        S_RUN: begin
          if (dp_ce) begin
            acc_cnt <= acc_cnt + AW'(1);
            if (acc_cnt == AW'(TOTAL - 1)) state <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          if (dp_ce) begin
            flush_cnt <= flush_cnt + FW'(1);
            if (flush_cnt == FW'(LATENCY - 1)) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (!out_valid || (out_ready && out_last)) state <= S_DONE;
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gaussian_ctrl.sv
// Self-checking bench for gaussian_ctrl on a small 8x4 frame, using a
// count-based reference model of produced/consumed results.
module tb_gaussian_ctrl;

  localparam int W     = 8;
  localparam int H     = 4;
  localparam int L     = 18;
  localparam int CW    = 9;
  localparam int TOTAL = W * H;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [7:0]    in_pixel;
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    dp_din;
  logic          dp_ce;
  logic          dp_sclr;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_x;
  logic [CW-1:0] out_y;
  logic          out_last;
  logic          busy;
  logic          frame_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gaussian_ctrl #(.WIDTH(W), .HEIGHT(H), .LATENCY(L), .CW(CW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .in_pixel(in_pixel), .in_valid(in_valid), .in_ready(in_ready),
    .dp_din(dp_din), .dp_ce(dp_ce), .dp_sclr(dp_sclr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_x(out_x), .out_y(out_y), .out_last(out_last),
    .busy(busy), .frame_done(frame_done)
  );

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] simulation timeout");
  end

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; in_valid = 1'b1; out_ready = 1'b1; in_pixel = 8'h5a;
    #1;
    checks++; if (in_ready !== 1'b0)   begin errors++; $display("[TB] FAIL reset in_ready got %b want 0", in_ready); end
    checks++; if (dp_ce !== 1'b0)      begin errors++; $display("[TB] FAIL reset dp_ce got %b want 0", dp_ce); end
    checks++; if (dp_sclr !== 1'b0)    begin errors++; $display("[TB] FAIL reset dp_sclr got %b want 0", dp_sclr); end
    checks++; if (out_valid !== 1'b0)  begin errors++; $display("[TB] FAIL reset out_valid got %b want 0", out_valid); end
    checks++; if (out_last !== 1'b0)   begin errors++; $display("[TB] FAIL reset out_last got %b want 0", out_last); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("[TB] FAIL reset frame_done got %b want 0", frame_done); end
    checks++; if (out_x !== '0 || out_y !== '0) begin errors++; $display("[TB] FAIL reset xy got %0d,%0d want 0,0", out_x, out_y); end
    checks++; if (busy !== 1'b0)       begin errors++; $display("[TB] FAIL reset busy got %b want 0", busy); end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL idle_in_ready got %b want 0", in_ready); end
    checks++; if (dp_ce !== 1'b0)    begin errors++; $display("[TB] FAIL idle_dp_ce got %b want 0", dp_ce); end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // vmode: 0 always valid, 1 toggling, 2 random; rmode: 0 always ready, 2 random.
  // bp_res/bp_flush: result index / flush step at which ready drops for 5 cycles.
  // rst_at: accept count at which rst is pulsed; poke_at: accept count for a stray start.
  task automatic run_frame(input string tag, input int vmode, input int rmode,
                           input int bp_res, input int bp_flush, input int rst_at,
                           input int poke_at);
    int acc = 0, fl = 0, prod = 0, cons = 0, steps = 0;
    int obs_ce = 0, obs_res = 0, hold = 0;
    bit done = 0, aborted = 0, bp_r_used = 0, bp_f_used = 0;
    bit run, flush, drain, e_valid, stall, e_rdy, e_ce, hs, last_hs;
    logic [CW-1:0] ex, ey;
    logic [7:0] e_din;

    @(negedge clk);
    start = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    checks++; if (dp_sclr !== 1'b1) begin errors++; $display("[TB] FAIL %s clear_sclr got %b want 1", tag, dp_sclr); end
    checks++; if (dp_ce !== 1'b0)   begin errors++; $display("[TB] FAIL %s clear_ce got %b want 0", tag, dp_ce); end

    for (int cyc = 0; cyc < 3000 && !done && !aborted; cyc++) begin
      @(negedge clk);
      start   = 1'b0;
      run     = acc < TOTAL;
      flush   = !run && fl < L;
      drain   = !run && !flush;
      e_valid = prod > cons;
      if (!bp_r_used && bp_res >= 0 && e_valid && cons == bp_res) begin hold = 5; bp_r_used = 1; end
      if (!bp_f_used && bp_flush >= 0 && flush && fl == bp_flush) begin hold = 5; bp_f_used = 1; end
      in_valid  = (vmode == 0) || (vmode == 1 && cyc % 2 == 0) || (vmode == 2 && $urandom_range(99) < 60);
      in_pixel  = 8'($urandom);
      out_ready = (hold > 0) ? 1'b0 : ((rmode == 0) ? 1'b1 : ($urandom_range(99) < 70));
      if (hold > 0) hold--;
      if (poke_at >= 0 && run && acc == poke_at) start = 1'b1;
      #1;
      stall = e_valid && !out_ready;
      e_rdy = run && !stall;
      e_ce  = run ? (in_valid && e_rdy) : (flush && !stall);
      e_din = run ? in_pixel : 8'd0;
      ex    = CW'(cons % W);
      ey    = CW'(cons / W);

      checks++; if (in_ready !== e_rdy)    begin errors++; $display("[TB] FAIL %s in_ready got %b want %b (acc %0d)", tag, in_ready, e_rdy, acc); end
      checks++; if (dp_ce !== e_ce)        begin errors++; $display("[TB] FAIL %s dp_ce got %b want %b (step %0d)", tag, dp_ce, e_ce, steps); end
      checks++; if (out_valid !== e_valid) begin errors++; $display("[TB] FAIL %s out_valid got %b want %b (step %0d)", tag, out_valid, e_valid, steps); end
      checks++; if (busy !== 1'b1 || dp_sclr !== 1'b0 || frame_done !== 1'b0) begin
        errors++; $display("[TB] FAIL %s status got busy=%b sclr=%b done=%b want 1,0,0", tag, busy, dp_sclr, frame_done);
      end
      if (run || flush) begin
        checks++; if (dp_din !== e_din) begin errors++; $display("[TB] FAIL %s dp_din got %h want %h", tag, dp_din, e_din); end
      end
      if (e_valid) begin
        checks++; if (out_x !== ex || out_y !== ey) begin errors++; $display("[TB] FAIL %s coord got %0d,%0d want %0d,%0d", tag, out_x, out_y, ex, ey); end
        checks++; if (out_last !== (cons == TOTAL - 1)) begin errors++; $display("[TB] FAIL %s out_last got %b want %b at result %0d", tag, out_last, cons == TOTAL - 1, cons); end
      end

      if (dp_ce === 1'b1) obs_ce++;
      if (out_valid === 1'b1 && out_ready) obs_res++;
      hs      = e_valid && out_ready;
      last_hs = hs && cons == TOTAL - 1;
      if (hs) cons++;
      if (e_ce) begin
        steps++;
        if (run) acc++; else fl++;
        if (steps > L) prod++;
      end
      if (drain && (!e_valid || last_hs)) done = 1;

      if (rst_at >= 0 && run && acc == rst_at) begin
        rst = 1'b1; in_valid = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0 || dp_ce !== 1'b0) begin
          errors++; $display("[TB] FAIL %s async_rst got busy=%b ov=%b rdy=%b ce=%b want 0", tag, busy, out_valid, in_ready, dp_ce);
        end
        checks++; if (out_x !== '0 || out_y !== '0 || out_last !== 1'b0) begin
          errors++; $display("[TB] FAIL %s async_rst_tag got %0d,%0d,%b want 0,0,0", tag, out_x, out_y, out_last);
        end
        @(negedge clk);
        rst = 1'b0;
        aborted = 1;
      end
    end

    if (aborted) return;
    if (!done) begin
      checks++; errors++;
      $display("[TB] FAIL %s timeout got %0d results want %0d", tag, cons, TOTAL);
      return;
    end

    in_valid = 1'b0;
    @(negedge clk); #1;
    checks++; if (frame_done !== 1'b1) begin errors++; $display("[TB] FAIL %s frame_done got %b want 1", tag, frame_done); end
    checks++; if (busy !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("[TB] FAIL %s done_state got busy=%b ov=%b want 1,0", tag, busy, out_valid); end
    @(negedge clk); #1;
    checks++; if (frame_done !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL %s idle_after got done=%b busy=%b want 0,0", tag, frame_done, busy); end
    checks++; if (obs_res !== TOTAL) begin errors++; $display("[TB] FAIL %s result_count got %0d want %0d", tag, obs_res, TOTAL); end
    checks++; if (obs_ce !== TOTAL + L) begin errors++; $display("[TB] FAIL %s step_count got %0d want %0d", tag, obs_ce, TOTAL + L); end
  endtask

  task automatic test_smooth_frame;
    run_frame("smooth", 0, 0, -1, -1, -1, -1);
  endtask

  task automatic test_source_gaps;
    run_frame("gaps", 1, 0, -1, -1, -1, -1);
  endtask

  task automatic test_backpressure;
    run_frame("backpressure", 0, 0, W + 3, -1, -1, -1);
  endtask

  task automatic test_flush_backpressure;
    run_frame("flush_bp", 0, 0, -1, 5, -1, -1);
  endtask

  task automatic test_reset_mid_frame;
    run_frame("rst_mid", 0, 0, -1, -1, 12, -1);
    run_frame("after_rst", 0, 0, -1, -1, -1, -1);
  endtask

  task automatic test_start_while_busy;
    run_frame("busy_start", 0, 0, -1, -1, -1, 5);
  endtask

  task automatic test_back_to_back;
    run_frame("random_a", 2, 2, -1, -1, -1, -1);
    run_frame("random_b", 2, 2, -1, -1, -1, -1);
  endtask

  initial begin
    test_reset;
    test_smooth_frame;
    test_source_gaps;
    test_backpressure;
    test_flush_backpressure;
    test_reset_mid_frame;
    test_start_while_busy;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gaussian_ctrl.md
Name: gaussian_ctrl

Overview:
Frame sequencer for the separable 5x5 Gaussian blur datapath. It accepts a raster pixel stream using a valid/ready handshake and drives the datapath clock-enable, synchronous clear and input pixel. It injects zero pixels at frame end to drain the line-buffer latency. It tags each datapath result with valid, x/y coordinates and last, and honours downstream backpressure.

Parameters:
WIDTH, 400, pixels per line (must equal line-buffer depth)
HEIGHT, 300, lines per frame
LATENCY, 802, datapath steps from pixel entry to its centred result (2*WIDTH+2)
CW, 9, width of x/y coordinate outputs (>= clog2(max(WIDTH,HEIGHT)))

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
start  in  1  one-cycle pulse that begins a frame; ignored unless in IDLE
in_pixel  in  8  source pixel
in_valid  in  1  source pixel valid
in_ready  out  1  controller accepts in_pixel this cycle
dp_din  out  8  pixel to datapath (in_pixel in RUN, 8'd0 in FLUSH)
dp_ce  out  1  datapath step enable; gates every datapath register
dp_sclr  out  1  datapath synchronous clear
out_valid  out  1  datapath dout is a valid result
out_ready  in  1  downstream accepts result
out_x  out  CW  column of current result
out_y  out  CW  row of current result
out_last  out  1  current result is the final pixel of the frame
busy  out  1  high in any state other than IDLE
frame_done  out  1  one-cycle pulse when the frame completes

Behaviour:
- Reset (async): state=IDLE. in_ready, dp_ce, dp_sclr, out_valid, out_last, frame_done all 0. out_x=out_y=0. All counters 0.
- States: IDLE -> CLEAR -> RUN -> FLUSH -> DRAIN -> DONE -> IDLE.
- IDLE: on start, go to CLEAR. Zero all counters.
- CLEAR: exactly 1 cycle; dp_sclr=1, dp_ce=0; go to RUN.
- stall = out_valid & ~out_ready.
- RUN: in_ready = ~stall; dp_ce = in_valid & in_ready; dp_din = in_pixel (combinational). After acceptance number WIDTH*HEIGHT, go to FLUSH. The next cycle after that acceptance already has in_ready=0.
- FLUSH: in_ready=0; dp_din=0; dp_ce = ~stall. After LATENCY flush steps, go to DRAIN.
- DRAIN: dp_ce=0. Wait until out_valid=0, or until out_valid & out_ready with out_last=1. Then go to DONE.
- DONE: frame_done=1 for 1 cycle; go to IDLE.
- Step counter s increments on every cycle with dp_ce=1. It is 1-based after the first step and reaches WIDTH*HEIGHT+LATENCY at the end of the frame.
- Output tagging, cycle-level:
  - After step s with s > LATENCY, out_valid=1 in the next cycle.
  - out_x/out_y are the coordinates of pixel p = s-LATENCY-1.
  - out_last = (p == WIDTH*HEIGHT-1).
  - Coordinates come from wrap counters (x wraps at WIDTH-1 and increments y). No divider.
- Handshake:
  - out_valid, out_x, out_y, out_last are held stable while stall=1.
  - No step occurs while stall=1, so dout is stable too.
  - On out_valid & out_ready with no step in the same cycle, out_valid goes 0 next cycle.
  - A step may coincide with the handshake. This gives 1 result/cycle throughput when out_ready is held high.
- Before LATENCY steps have completed, steps produce no out_valid (pipeline fill).
- start outside IDLE is ignored. A source presenting in_valid outside RUN is not accepted.
- Async rst in any state returns to IDLE in the same cycle; any partial frame is discarded. The next frame's CLEAR wipes the datapath state.
- Result count per frame is exactly WIDTH*HEIGHT.

Test Plan:
(Parameters WIDTH=8, HEIGHT=4, LATENCY=18 unless stated.)
- Smooth frame: out_ready=1, in_valid=1 continuously, pulse start.
  - dp_sclr high for exactly 1 cycle.
  - 32 accepts, then 18 flush steps.
  - The first out_valid appears 1 cycle after step 19 with (0,0).
  - 32 results in raster order; out_last on (7,3); frame_done 1 cycle later.
- Source gaps: in_valid toggles 1,0,1,0 -> dp_ce only on accepts; still 32 results with correct coordinates.
- Backpressure: out_ready low for 5 cycles mid-frame at (3,1).
  - in_ready=0, dp_ce=0, and out_x/out_y/dp output held constant.
  - On release, results resume at (4,1) with no loss or duplication.
- Flush backpressure: out_ready low during FLUSH -> flush steps pause; total flush steps still 18; frame_done follows the accepted last.
- Reset mid-frame: assert rst at pixel 12.
  - All outputs go to 0 immediately and state=IDLE.
  - A new start gives a clean 32-result frame beginning at (0,0).
- start while busy: pulse start during RUN -> ignored; result count and coordinates unchanged.
